ccff_bitstream_loader: RTL and testbench
========================================

Name: ccff_bitstream_loader

Overview:
- Configuration-chain feeder sitting directly upstream of the CLB fle tiles' ccff_head input.
- Accepts configuration bitstream words over a valid/ready handshake and serializes them MSB-first onto the ccff chain, one bit per prog_clk cycle.
- Drives a per-bit shift enable and counts exactly CHAIN_LENGTH bits, then signals done.
- Folds the bits shifted out of ccff_tail into a parity value so the previously loaded configuration can be checked.

Parameters:
- WORD_WIDTH, 8, width of each input bitstream word.
- CHAIN_LENGTH, 20, total number of configuration flip-flops between ccff_head and ccff_tail.
- CNT_W, $clog2(CHAIN_LENGTH+1), width of the bit counter (derived).

Ports:
- prog_clk  input  1  programming clock; all state updates on its rising edge.
- pReset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a load; honoured only in IDLE or DONE.
- in_valid  input  1  in_data holds a valid bitstream word.
- in_data  input  WORD_WIDTH  bitstream word; bit [WORD_WIDTH-1] is shifted first.
- in_ready  output  1  loader accepts in_data at this edge when in_valid is high.
- ccff_head  output  1  serial configuration bit to the chain.
- ccff_en  output  1  shift enable; the chain captures ccff_head at an edge only when ccff_en=1.
- ccff_tail  input  1  serial bit returned from the chain end.
- busy  output  1  high while in LOAD.
- done  output  1  high from load completion until the next accepted start or reset.
- bit_count  output  CNT_W  number of bits shifted in the current or last load.
- readback_parity  output  1  XOR of all ccff_tail samples taken during the current or last load.

Behaviour:
- Reset: synchronous, active-high on pReset at the prog_clk edge. All outputs go to 0 and state goes to IDLE. The word buffer and its counter are cleared.
- Reset mid-load aborts immediately. Chain contents are then undefined, and done stays 0.
- States: IDLE, LOAD, DONE.
- IDLE -> LOAD on start. DONE -> LOAD on start.
- On entering LOAD: bit_count=0, readback_parity=0, done=0, buffer empty.
- start is ignored while in LOAD.
- Word buffer: a WORD_WIDTH shift register plus buf_cnt, the number of unshifted bits it holds.
- in_ready = LOAD && remaining>0 && (buf_cnt==0 || buf_cnt==1), where remaining = CHAIN_LENGTH - bit_count - buf_cnt.
- Handshake:
  - A word transfers on an edge where in_valid && in_ready.
  - The buffer loads in_data and sets buf_cnt = min(WORD_WIDTH, remaining).
  - If buf_cnt was 1, that last old bit shifts on the same edge, giving back-to-back words with no bubble.
- Shift:
  - ccff_en = LOAD && buf_cnt>0. ccff_en and ccff_head are registered outputs.
  - ccff_head = buffer MSB.
  - On each edge with ccff_en=1: bit_count+1, buf_cnt-1, buffer shifts left, readback_parity ^= ccff_tail.
- Stall: with an empty buffer and in_valid low, ccff_en=0 and the chain holds. There is no timeout.
- Latency: the first word is accepted at edge N; ccff_en=1 and ccff_head = in_data[WORD_WIDTH-1] during cycle N+1.
- Throughput: 1 bit per cycle when words arrive on time.
- Final word: only the top `remaining` bits are used. The unused low bits are discarded and never reach ccff_head.
- Completion: on the edge where bit_count reaches CHAIN_LENGTH:
  - next state is DONE, done=1, busy=0;
  - ccff_en=0 from the next cycle;
  - in_ready stays 0 in DONE.
- Readback: readback_parity is the parity of the old chain contents after exactly CHAIN_LENGTH shifts.
- Simultaneous events:
  - pReset dominates everything.
  - In DONE, start together with in_valid: the word is not accepted in that cycle, because in_ready is 0 outside LOAD.
- CHAIN_LENGTH not a multiple of WORD_WIDTH is legal; no extra bits are shifted.
- Outputs hold stable while ccff_en=0.

Test Plan:
- Reset: assert pReset mid-LOAD after 5 bits -> next cycle state IDLE; ccff_en=0, busy=0, done=0, in_ready=0, bit_count=0.
- Nominal load: start, then words 8'hA5, 8'h3C, 8'hF0 with in_valid held high -> ccff_head sequence 1010_0101_0011_1100_1111 over 20 consecutive ccff_en cycles with no bubble; done=1 and bit_count=20; low nibble 0000 of 8'hF0 never shifted.
- Stall: drop in_valid for 4 cycles after the first word -> ccff_en=0 for exactly those gap cycles; total ccff_en cycles still 20; final chain contents identical to the nominal load.
- Readback: a model chain preloaded with 20 bits holding 7 ones, then any load -> readback_parity=1. Repeat with 6 ones -> readback_parity=0.
- Start handling: start pulses during LOAD ignored, bit_count uninterrupted. start in DONE -> done=0, bit_count=0, new load begins; in_data presented alongside that start not accepted.
- Edge size: CHAIN_LENGTH=8, WORD_WIDTH=8, single word 8'h81 -> exactly 8 shifts, in_ready never reasserts, done=1 the cycle after the 8th shift.

Source files
------------

// File: rtl/ccff_bitstream_loader_if.sv
// Bitstream word handshake between a configuration source and the ccff loader.
interface ccff_bitstream_loader_if #(
   parameter int WORD_WIDTH = 8
);
   logic                  in_valid;
   logic [WORD_WIDTH-1:0] in_data;
   logic                  in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/ccff_bitstream_loader.sv
// Serializes configuration words MSB-first onto the ccff chain, counts exactly
// CHAIN_LENGTH shifts and folds the bits returned on ccff_tail into a parity.
module ccff_bitstream_loader #(
   parameter int WORD_WIDTH   = 8,
   parameter int CHAIN_LENGTH = 20,
   parameter int CNT_W        = $clog2(CHAIN_LENGTH + 1)
) (
   input  logic                    prog_clk,
   input  logic                    pReset,
   input  logic                    start,
   ccff_bitstream_loader_if.slave  in_if,
   output logic                    ccff_head,
   output logic                    ccff_en,
   input  logic                    ccff_tail,
   output logic                    busy,
   output logic                    done,
   output logic [CNT_W-1:0]        bit_count,
   output logic                    readback_parity
);

   localparam int BC_W = $clog2(WORD_WIDTH + 1);
   localparam logic [CNT_W-1:0] CL_C = CNT_W'(CHAIN_LENGTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DONE
   } state_e;

   state_e                state_q, state_d;
   logic [WORD_WIDTH-1:0] buf_q, buf_d;
   logic [BC_W-1:0]       buf_cnt_q, buf_cnt_d;
   logic [CNT_W-1:0]      bit_count_q, bit_count_d;
   logic                  parity_q, parity_d;

   logic [CNT_W-1:0]      remaining;
   logic [BC_W-1:0]       fill;
   logic                  shift;
   logic                  accept;

   // Bits of the chain not yet counted nor already sitting in the buffer.
   assign remaining = CL_C - bit_count_q - CNT_W'(buf_cnt_q);
   assign fill      = (32'(remaining) >= WORD_WIDTH) ? BC_W'(WORD_WIDTH) : BC_W'(remaining);

   assign shift          = (state_q == S_LOAD) && (buf_cnt_q != '0);
   assign in_if.in_ready = (state_q == S_LOAD) && (remaining != '0) && (buf_cnt_q <= BC_W'(1));
   assign accept         = in_if.in_valid && in_if.in_ready;

   assign ccff_en         = shift;
   assign ccff_head       = buf_q[WORD_WIDTH-1];
   assign busy            = (state_q == S_LOAD);
   assign done            = (state_q == S_DONE);
   assign bit_count       = bit_count_q;
   assign readback_parity = parity_q;

   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         state_q     <= S_IDLE;
         buf_q       <= '0;
         buf_cnt_q   <= '0;
         bit_count_q <= '0;
         parity_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         buf_q       <= buf_d;
         buf_cnt_q   <= buf_cnt_d;
         bit_count_q <= bit_count_d;
         parity_q    <= parity_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      buf_d       = buf_q;
      buf_cnt_d   = buf_cnt_q;
      bit_count_d = bit_count_q;
      parity_d    = parity_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d     = S_LOAD;
               buf_d       = '0;
               buf_cnt_d   = '0;
               bit_count_d = '0;
               parity_d    = 1'b0;
            end
         end
         S_LOAD: begin
            if (shift) begin
               bit_count_d = bit_count_q + CNT_W'(1);
               parity_d    = parity_q ^ ccff_tail;
               buf_d       = buf_q << 1;
               buf_cnt_d   = buf_cnt_q - BC_W'(1);
            end
            // A new word overrides the shift of a 1-bit buffer: that bit is counted above.
            if (accept) begin
               buf_d     = in_if.in_data;
               buf_cnt_d = fill;
            end
            // Clearing the buffer keeps discarded low bits off ccff_head.
            if (bit_count_d == CL_C) begin
               state_d   = S_DONE;
               buf_d     = '0;
               buf_cnt_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Scoreboard bench for ccff_bitstream_loader with a behavioural 20-bit chain model.
module tb_ccff_bitstream_loader;

   localparam int CL = 20;

   logic       prog_clk = 1'b0;
   logic       pReset, start, ccff_head, ccff_en, ccff_tail, busy, done, readback_parity;
   logic [4:0] bit_count;

   logic       start2, ccff_head2, ccff_en2, busy2, done2, parity2;
   logic [3:0] bit_count2;

   logic [19:0] chain;
   logic [19:0] preload_val;
   logic        preload;

   logic sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   pushed, en_cnt, first_en, last_en, cyc;

   always #5 prog_clk = ~prog_clk;

   ccff_bitstream_loader_if #(.WORD_WIDTH(8)) bus ();
   ccff_bitstream_loader_if #(.WORD_WIDTH(8)) bus2 ();

   ccff_bitstream_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(CL)) dut (
      .prog_clk(prog_clk), .pReset(pReset), .start(start), .in_if(bus),
      .ccff_head(ccff_head), .ccff_en(ccff_en), .ccff_tail(ccff_tail),
      .busy(busy), .done(done), .bit_count(bit_count), .readback_parity(readback_parity)
   );

   ccff_bitstream_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(8)) dut2 (
      .prog_clk(prog_clk), .pReset(pReset), .start(start2), .in_if(bus2),
      .ccff_head(ccff_head2), .ccff_en(ccff_en2), .ccff_tail(1'b0),
      .busy(busy2), .done(done2), .bit_count(bit_count2), .readback_parity(parity2)
   );

   assign ccff_tail = chain[19];

   always @(posedge prog_clk) begin
      if (preload)      chain <= preload_val;
      else if (ccff_en) chain <= {chain[18:0], ccff_head};
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge prog_clk);
         cyc++;
         if (ccff_en) begin
            if (sb_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else                  chk("ccff_head", 32'(ccff_head), 32'(sb_q.pop_front()));
            if (en_cnt == 0) first_en = cyc;
            last_en = cyc;
            en_cnt++;
         end
      end
   endtask

   task automatic new_load();
      sb_q.delete();
      pushed = 0;
      en_cnt = 0;
   endtask

   task automatic preload_chain(input logic [19:0] v);
      preload_val = v;
      preload = 1'b1;
      @(posedge prog_clk); #1;
      preload = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge prog_clk); #1;
      start = 1'b0;
   endtask

   // Called #1 after a posedge; returns #1 after the accepting edge with in_valid still high.
   task automatic send(input logic [7:0] w);
      bit ok = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         if (pushed < CL) begin
            sb_q.push_back(w[i]);
            pushed++;
         end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      for (int k = 0; k < 64 && !ok; k++) begin
         @(negedge prog_clk);
         if (bus.in_ready) ok = 1'b1;
      end
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge prog_clk); #1;
   endtask

   task automatic wait_done();
      bit ok = 1'b0;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge prog_clk);
         if (done) ok = 1'b1;
      end
      if (!ok) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_done(input string tag, input logic [19:0] exp_chain, input logic exp_par);
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_en"}, 32'(ccff_en), 32'd0);
      chk({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
      chk({tag, "_bitcnt"}, 32'(bit_count), 32'd20);
      chk({tag, "_en_cycles"}, 32'(en_cnt), 32'd20);
      chk({tag, "_sb_left"}, 32'(sb_q.size()), 32'd0);
      chk({tag, "_chain"}, 32'(chain), 32'(exp_chain));
      chk({tag, "_parity"}, 32'(readback_parity), 32'(exp_par));
   endtask

   initial begin
      bit         ok;
      int         n2, last2, done_at;
      bit         rdy_seen;
      logic [7:0] got2;

      pReset = 1'b1; start = 1'b0; start2 = 1'b0; preload = 1'b0; preload_val = '0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus2.in_valid = 1'b0; bus2.in_data = '0;
      cyc = 0; first_en = 0; last_en = 0;
      new_load();
      fork monitor(); join_none
      repeat (2) @(posedge prog_clk);
      #1 pReset = 1'b0;
      @(negedge prog_clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_en", 32'(ccff_en), 32'd0);
      chk("rst_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_bitcnt", 32'(bit_count), 32'd0);
      chk("rst_parity", 32'(readback_parity), 32'd0);
      chk("rst_done2", 32'(done2), 32'd0);
      @(posedge prog_clk); #1;

      // Nominal load with start pulses sprinkled through it.
      preload_chain(20'h00000);
      new_load();
      do_start();
      fork
         begin
            send(8'hA5); send(8'h3C); send(8'hF0);
            bus.in_valid = 1'b0;
         end
         begin
            repeat (3) begin
               repeat (2) @(posedge prog_clk);
               #1 start = 1'b1;
               @(posedge prog_clk);
               #1 start = 1'b0;
            end
         end
      join
      wait_done();
      check_done("nom", 20'hA53CF, 1'b0);
      chk("nom_span", 32'(last_en - first_en + 1), 32'd20);

      // Readback of 7 ones.
      @(posedge prog_clk); #1;
      preload_chain(20'h0007F);
      new_load();
      do_start();
      send(8'hA5); send(8'h3C); send(8'hF0);
      bus.in_valid = 1'b0;
      wait_done();
      check_done("rb7", 20'hA53CF, 1'b1);

      // Readback of 6 ones with a 4-cycle input stall after the first word.
      @(posedge prog_clk); #1;
      preload_chain(20'h0003F);
      new_load();
      do_start();
      send(8'hA5);
      bus.in_valid = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 64 && !ok; k++) begin
         @(negedge prog_clk);
         if (bus.in_ready) ok = 1'b1;
      end
      if (!ok) chk("stall_ready_timeout", 32'd0, 32'd1);
      repeat (4) @(posedge prog_clk);
      #1;
      send(8'h3C); send(8'hF0);
      bus.in_valid = 1'b0;
      wait_done();
      check_done("stall", 20'hA53CF, 1'b0);
      chk("stall_gap", 32'(last_en - first_en + 1 - en_cnt), 32'd4);

      // Start in DONE alongside a word that must not be taken.
      @(posedge prog_clk); #1;
      new_load();
      start = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h5A;
      @(posedge prog_clk); #1;
      start = 1'b0;
      chk("restart_done", 32'(done), 32'd0);
      chk("restart_bitcnt", 32'(bit_count), 32'd0);
      chk("restart_busy", 32'(busy), 32'd1);
      chk("restart_en", 32'(ccff_en), 32'd0);
      send(8'hC3); send(8'h0F); send(8'h96);
      bus.in_valid = 1'b0;
      wait_done();
      chk("restart_bitcnt_end", 32'(bit_count), 32'd20);
      chk("restart_en_cycles", 32'(en_cnt), 32'd20);
      chk("restart_sb_left", 32'(sb_q.size()), 32'd0);

      // Reset mid-load after 5 shifts.
      @(posedge prog_clk); #1;
      new_load();
      do_start();
      send(8'hA5);
      bus.in_valid = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 64 && !ok; k++) begin
         @(negedge prog_clk);
         if (bit_count == 5'd5) ok = 1'b1;
      end
      if (!ok) chk("midrst_timeout", 32'd0, 32'd1);
      pReset = 1'b1;
      @(posedge prog_clk); #1;
      pReset = 1'b0;
      chk("midrst_en", 32'(ccff_en), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_ready", 32'(bus.in_ready), 32'd0);
      chk("midrst_bitcnt", 32'(bit_count), 32'd0);
      chk("midrst_head", 32'(ccff_head), 32'd0);
      sb_q.delete();

      // Single-word chain on the 8-bit instance.
      start2 = 1'b1;
      @(posedge prog_clk); #1;
      start2 = 1'b0;
      bus2.in_valid = 1'b1; bus2.in_data = 8'h81;
      @(negedge prog_clk);
      chk("e8_ready", 32'(bus2.in_ready), 32'd1);
      @(posedge prog_clk); #1;
      bus2.in_data = 8'hFF;
      n2 = 0; last2 = -1; done_at = -1; rdy_seen = 1'b0; got2 = '0;
      for (int k = 0; k < 14; k++) begin
         @(negedge prog_clk);
         if (ccff_en2) begin
            got2 = {got2[6:0], ccff_head2};
            n2++;
            last2 = k;
         end
         if (bus2.in_ready) rdy_seen = 1'b1;
         if (done2 && done_at < 0) done_at = k;
      end
      bus2.in_valid = 1'b0;
      chk("e8_bits", 32'(got2), 32'h81);
      chk("e8_shifts", 32'(n2), 32'd8);
      chk("e8_ready_again", 32'(rdy_seen), 32'd0);
      chk("e8_done_at", 32'(done_at), 32'(last2 + 1));
      chk("e8_done", 32'(done2), 32'd1);
      chk("e8_bitcnt", 32'(bit_count2), 32'd8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
